// File: rtl/if_id_reg.sv
// IF/ID pipeline register for an 8-bit fetch stream.
// It assembles two-byte instructions (opcode 4'hC_) with their immediate byte.
// Optional feature: define IF_ID_IMM_FETCH_EN to build in the opcode/immediate
// assembly FSM. When it is undefined, every byte is a one-byte instruction.
// Reset is asynchronous and active-high.
module if_id_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       flush,
  input  logic [7:0] instr_in,
  input  logic [7:0] pc_in,
  input  logic [7:0] pc_plus1_in,
  output logic [7:0] instr_out,
  output logic [7:0] imm_out,
  output logic [7:0] IP_out,
  output logic [7:0] pc_plus1_out,
  output logic       valid_out,
  output logic       imm_busy
);

  localparam int unsigned W = 8;

  // Registered stage contents
  logic [W-1:0] instr_q, instr_d;
  logic [W-1:0] ip_q, ip_d;
  logic [W-1:0] pc1_q, pc1_d;
  logic         valid_q, valid_d;

  assign instr_out    = instr_q;
  assign IP_out       = ip_q;
  assign pc_plus1_out = pc1_q;
  assign valid_out    = valid_q;

`ifdef IF_ID_IMM_FETCH_EN

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] hold_op_q, hold_op_d;
  logic [W-1:0] hold_pc_q, hold_pc_d;
  logic [W-1:0] imm_q, imm_d;
  logic         is_two_byte;

  assign is_two_byte = (instr_in[7:4] == 4'hC);
  assign imm_out     = imm_q;
  assign imm_busy    = (state_q == S_IMM);

  // State and partial-instruction hold registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_OP;
      hold_op_q <= '0;
      hold_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_op_q <= hold_op_d;
      hold_pc_q <= hold_pc_d;
    end
  end

  // Next state and next stage contents; priority is flush, then stall, then load
  always_comb begin
    state_d   = state_q;
    hold_op_d = hold_op_q;
    hold_pc_d = hold_pc_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    ip_d      = ip_q;
    pc1_d     = pc1_q;
    valid_d   = valid_q;

    if (flush) begin
      // Squash to a NOP but keep the PC context for interrupt return
      state_d   = S_OP;
      hold_op_d = '0;
      hold_pc_d = '0;
      instr_d   = '0;
      imm_d     = '0;
      valid_d   = 1'b0;
      ip_d      = pc_in;
      pc1_d     = pc_plus1_in;
    end else if (!stall) begin
      case (state_q)
        S_OP: begin
          if (is_two_byte) begin
            // Park the opcode and emit a bubble while the immediate is fetched
            state_d   = S_IMM;
            hold_op_d = instr_in;
            hold_pc_d = pc_in;
            instr_d   = '0;
            imm_d     = '0;
            valid_d   = 1'b0;
          end else begin
            instr_d = instr_in;
            imm_d   = '0;
            ip_d    = pc_in;
            pc1_d   = pc_plus1_in;
            valid_d = 1'b1;
          end
        end
        S_IMM: begin
          // The whole byte is data here; its upper nibble is not decoded
          state_d = S_OP;
          instr_d = hold_op_q;
          imm_d   = instr_in;
          ip_d    = hold_pc_q;
          pc1_d   = pc_plus1_in;
          valid_d = 1'b1;
        end
        default: begin
          state_d = S_OP;
        end
      endcase
    end
  end

  // Immediate output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_q <= '0;
    end else begin
      imm_q <= imm_d;
    end
  end

`else

  assign imm_out  = '0;
  assign imm_busy = 1'b0;

  // Next stage contents for one-byte-only decode; flush beats stall
  always_comb begin
    instr_d = instr_q;
    ip_d    = ip_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;

    if (flush) begin
      instr_d = '0;
      valid_d = 1'b0;
      ip_d    = pc_in;
      pc1_d   = pc_plus1_in;
    end else if (!stall) begin
      instr_d = instr_in;
      ip_d    = pc_in;
      pc1_d   = pc_plus1_in;
      valid_d = 1'b1;
    end
  end

`endif

  // Stage output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      ip_q    <= '0;
      pc1_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      ip_q    <= ip_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_id_reg.sv
// Directed table-driven bench for if_id_reg (both IF_ID_IMM_FETCH_EN builds).
module tb_if_id_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       flush;
  logic [7:0] instr_in;
  logic [7:0] pc_in;
  logic [7:0] pc_plus1_in;
  logic [7:0] instr_out;
  logic [7:0] imm_out;
  logic [7:0] IP_out;
  logic [7:0] pc_plus1_out;
  logic       valid_out;
  logic       imm_busy;

  int n_vec = 0;
  int n_err = 0;

  if_id_reg dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .instr_in     (instr_in),
    .pc_in        (pc_in),
    .pc_plus1_in  (pc_plus1_in),
    .instr_out    (instr_out),
    .imm_out      (imm_out),
    .IP_out       (IP_out),
    .pc_plus1_out (pc_plus1_out),
    .valid_out    (valid_out),
    .imm_busy     (imm_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic       flush;
    logic [7:0] instr;
    logic [7:0] pc;
    logic [7:0] pc1;
    logic [7:0] e_instr;
    logic [7:0] e_imm;
    logic [7:0] e_ip;
    logic [7:0] e_pc1;
    logic       e_valid;
    logic       e_busy;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [7:0] ei, input logic [7:0] em,
                       input logic [7:0] ep, input logic [7:0] e1, input logic ev,
                       input logic eb);
    n_vec++;
    if (instr_out !== ei || imm_out !== em || IP_out !== ep || pc_plus1_out !== e1 ||
        valid_out !== ev || imm_busy !== eb) begin
      n_err++;
      $display("FAIL %s: got instr=%h imm=%h ip=%h pc1=%h valid=%b busy=%b, want instr=%h imm=%h ip=%h pc1=%h valid=%b busy=%b",
               name, instr_out, imm_out, IP_out, pc_plus1_out, valid_out, imm_busy,
               ei, em, ep, e1, ev, eb);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic [7:0] i,
                       input logic [7:0] p, input logic [7:0] p1);
    @(negedge clk);
    stall = s; flush = f; instr_in = i; pc_in = p; pc_plus1_in = p1;
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef IF_ID_IMM_FETCH_EN
    //          st fl instr  pc     pc1    e_instr e_imm  e_ip   e_pc1  v  busy
    tbl[0]  = '{0, 0, 8'h25, 8'h10, 8'h11, 8'h25, 8'h00, 8'h10, 8'h11, 1, 0};
    tbl[1]  = '{0, 0, 8'hC1, 8'h20, 8'h21, 8'h00, 8'h00, 8'h10, 8'h11, 0, 1};
    tbl[2]  = '{0, 0, 8'h7F, 8'h21, 8'h22, 8'hC1, 8'h7F, 8'h20, 8'h22, 1, 0};
    tbl[3]  = '{0, 0, 8'hC2, 8'h30, 8'h31, 8'h00, 8'h00, 8'h20, 8'h22, 0, 1};
    tbl[4]  = '{1, 0, 8'h55, 8'h31, 8'h32, 8'h00, 8'h00, 8'h20, 8'h22, 0, 1};
    tbl[5]  = '{1, 0, 8'h56, 8'h31, 8'h32, 8'h00, 8'h00, 8'h20, 8'h22, 0, 1};
    tbl[6]  = '{1, 0, 8'h57, 8'h31, 8'h32, 8'h00, 8'h00, 8'h20, 8'h22, 0, 1};
    tbl[7]  = '{0, 0, 8'h44, 8'h31, 8'h32, 8'hC2, 8'h44, 8'h30, 8'h32, 1, 0};
    tbl[8]  = '{0, 0, 8'hC3, 8'h50, 8'h51, 8'h00, 8'h00, 8'h30, 8'h32, 0, 1};
    tbl[9]  = '{0, 1, 8'hAA, 8'h3F, 8'h40, 8'h00, 8'h00, 8'h3F, 8'h40, 0, 0};
    tbl[10] = '{0, 0, 8'h30, 8'h40, 8'h41, 8'h30, 8'h00, 8'h40, 8'h41, 1, 0};
    tbl[11] = '{0, 0, 8'hC5, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h40, 8'h41, 0, 1};
    tbl[12] = '{0, 0, 8'h99, 8'h00, 8'h01, 8'hC5, 8'h99, 8'hFF, 8'h01, 1, 0};
    tbl[13] = '{1, 1, 8'h12, 8'h60, 8'h61, 8'h00, 8'h00, 8'h60, 8'h61, 0, 0};
    tbl[14] = '{1, 0, 8'h13, 8'h61, 8'h62, 8'h00, 8'h00, 8'h60, 8'h61, 0, 0};
    tbl[15] = '{0, 0, 8'hC7, 8'h70, 8'h71, 8'h00, 8'h00, 8'h60, 8'h61, 0, 1};
`else
    tbl[0]  = '{0, 0, 8'h25, 8'h10, 8'h11, 8'h25, 8'h00, 8'h10, 8'h11, 1, 0};
    tbl[1]  = '{0, 0, 8'hC1, 8'h20, 8'h21, 8'hC1, 8'h00, 8'h20, 8'h21, 1, 0};
    tbl[2]  = '{0, 0, 8'h7F, 8'h21, 8'h22, 8'h7F, 8'h00, 8'h21, 8'h22, 1, 0};
    tbl[3]  = '{0, 0, 8'hC2, 8'h30, 8'h31, 8'hC2, 8'h00, 8'h30, 8'h31, 1, 0};
    tbl[4]  = '{1, 0, 8'h55, 8'h31, 8'h32, 8'hC2, 8'h00, 8'h30, 8'h31, 1, 0};
    tbl[5]  = '{1, 0, 8'h56, 8'h31, 8'h32, 8'hC2, 8'h00, 8'h30, 8'h31, 1, 0};
    tbl[6]  = '{1, 0, 8'h57, 8'h31, 8'h32, 8'hC2, 8'h00, 8'h30, 8'h31, 1, 0};
    tbl[7]  = '{0, 0, 8'h44, 8'h31, 8'h32, 8'h44, 8'h00, 8'h31, 8'h32, 1, 0};
    tbl[8]  = '{0, 0, 8'hC3, 8'h50, 8'h51, 8'hC3, 8'h00, 8'h50, 8'h51, 1, 0};
    tbl[9]  = '{0, 1, 8'hAA, 8'h3F, 8'h40, 8'h00, 8'h00, 8'h3F, 8'h40, 0, 0};
    tbl[10] = '{0, 0, 8'h30, 8'h40, 8'h41, 8'h30, 8'h00, 8'h40, 8'h41, 1, 0};
    tbl[11] = '{0, 0, 8'hC5, 8'hFF, 8'h00, 8'hC5, 8'h00, 8'hFF, 8'h00, 1, 0};
    tbl[12] = '{0, 0, 8'h99, 8'h00, 8'h01, 8'h99, 8'h00, 8'h00, 8'h01, 1, 0};
    tbl[13] = '{1, 1, 8'h12, 8'h60, 8'h61, 8'h00, 8'h00, 8'h60, 8'h61, 0, 0};
    tbl[14] = '{1, 0, 8'h13, 8'h61, 8'h62, 8'h00, 8'h00, 8'h60, 8'h61, 0, 0};
    tbl[15] = '{0, 0, 8'hC7, 8'h70, 8'h71, 8'hC7, 8'h00, 8'h70, 8'h71, 1, 0};
`endif

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    instr_in = 8'hEE; pc_in = 8'hEE; pc_plus1_in = 8'hEF;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].stall, tbl[i].flush, tbl[i].instr, tbl[i].pc, tbl[i].pc1);
      check($sformatf("vec%0d", i), tbl[i].e_instr, tbl[i].e_imm, tbl[i].e_ip,
            tbl[i].e_pc1, tbl[i].e_valid, tbl[i].e_busy);
    end

    // Asynchronous reset mid-operation, checked between clock edges
    @(negedge clk);
    stall = 1'b0; flush = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("async_rst", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("rst_release", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    // First byte after reset must be decoded as an opcode
    drive(1'b0, 1'b0, 8'h09, 8'h80, 8'h81);
    check("post_rst_op", 8'h09, 8'h00, 8'h80, 8'h81, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 stall  input  1  hazard hold; freezes all state and outputs.
REQ-004 flush  input  1  branch/interrupt squash; converts current stage contents to NOP.
REQ-005 instr_in  input  8  fetched byte from instruction memory.
REQ-006 pc_in  input  8  address of instr_in.
REQ-007 pc_plus1_in  input  8  pc_in + 1 from fetch adder.
REQ-008 instr_out  output  8  opcode byte to decode; 8'h00 = NOP.
REQ-009 imm_out  output  8  immediate byte of a two-byte instruction; 8'h00 otherwise.
REQ-010 IP_out  output  8  address of the opcode byte of instr_out.
REQ-011 pc_plus1_out  output  8  address following the last byte of the instruction.
REQ-012 valid_out  output  1  1 = instr_out is a real instruction; 0 = bubble.
REQ-013 imm_busy  output  1  1 while waiting for an immediate byte (state S_IMM).

Function
REQ-014 Two-byte instruction: instr_in[7:4] == 4'hC; all other opcodes are one byte.
REQ-015 FSM states: S_OP (expect opcode), S_IMM (expect immediate); imm_busy = (state == S_IMM).
REQ-016 Priority per edge: rst > flush > stall > normal load.
REQ-017 S_OP, normal, one-byte opcode: instr_out<=instr_in, imm_out<=0, IP_out<=pc_in, pc_plus1_out<=pc_plus1_in, valid_out<=1; stay S_OP.
REQ-018 S_OP, normal, two-byte opcode: opcode and pc_in into internal hold regs; outputs <= bubble (instr_out=0, imm_out=0, valid_out=0, IP_out/pc_plus1_out hold); go S_IMM.
REQ-019 S_IMM, normal: instr_out<=held opcode, imm_out<=instr_in, IP_out<=held pc, pc_plus1_out<=pc_plus1_in, valid_out<=1; go S_OP; opcode field of the immediate byte is ignored.
REQ-020 Latency: one-byte instr visible 1 cycle after its fetch edge; two-byte instr visible 1 cycle after immediate fetch edge.
REQ-021 stall=1 (no flush): state, hold regs and all outputs unchanged, in either state.
REQ-022 flush=1: instr_out<=0, imm_out<=0, valid_out<=0, state<=S_OP, hold regs cleared; pc_plus1_out<=pc_plus1_in, IP_out<=pc_in (PC context for interrupt return kept).
REQ-023 flush and stall together: flush behaviour applies.
REQ-024 Flush in S_IMM abandons the partial instruction; no partial opcode is ever emitted.
REQ-025 Address arithmetic is 8-bit; wrap from 8'hFF to 8'h00 handled by upstream adder, passed through unchanged (opcode at 8'hFF, immediate at 8'h00 is legal).

Reset
REQ-026 rst=1 asynchronously forces: state=S_OP, hold regs=0, instr_out=0, imm_out=0, IP_out=0, pc_plus1_out=0, valid_out=0, imm_busy=0.
REQ-027 Reset asserted in S_IMM discards the held opcode; first edge after release treats instr_in as an opcode.

Configuration
REQ-028 Macro IF_ID_IMM_FETCH_EN defined: two-byte FSM per REQ-014..REQ-024 compiled in.
REQ-029 Macro undefined: no FSM; every byte is a one-byte instruction per REQ-017, imm_out and imm_busy tied to 0; stall/flush/reset rules unchanged.

Verification
REQ-030 rst=1 mid-operation, then release -> all outputs 0 immediately (async), no clock edge needed.
REQ-031 instr_in=8'h25, pc_in=8'h10, pc_plus1_in=8'h11 -> next edge: instr_out=8'h25, imm_out=0, IP_out=8'h10, pc_plus1_out=8'h11, valid_out=1.
REQ-032 instr_in=8'hC1 @pc 8'h20, then 8'h7F @pc 8'h21 -> first edge: valid_out=0, imm_busy=1; second edge: instr_out=8'hC1, imm_out=8'h7F, IP_out=8'h20, pc_plus1_out=8'h22, valid_out=1, imm_busy=0.
REQ-033 In S_IMM with opcode 8'hC2 held, stall=1 for 3 cycles then immediate 8'h44 -> outputs frozen during stall, then instr_out=8'hC2, imm_out=8'h44.
REQ-034 In S_IMM, flush=1 with pc_plus1_in=8'h40 -> instr_out=0, valid_out=0, imm_busy=0, pc_plus1_out=8'h40; next byte 8'h30 decoded as one-byte opcode.
REQ-035 Opcode 8'hC5 at pc 8'hFF, immediate 8'h99 at pc 8'h00 (pc_plus1_in=8'h01) -> instr_out=8'hC5, imm_out=8'h99, IP_out=8'hFF, pc_plus1_out=8'h01.
